vector_reg_file: RTL and testbench
==================================

Name: vector_reg_file

Overview:
- Vector register file for the CVP14 vector processor: 8 registers × 256 bits, each holding 16 lanes of 16 bits.
- Provides two independent combinational read ports and one synchronous write port.
- Feeds VADD/VDOT/VLD/VST datapaths; written back from ALU/memory results.

Parameters:
NUM_REGS, 8, number of vector registers (address width = log2(NUM_REGS) = 3)
ELEM_WIDTH, 16, bits per vector lane
NUM_ELEMS, 16, lanes per register (register width = ELEM_WIDTH*NUM_ELEMS = 256)

Ports:
clk  input  1  clock; all writes on rising edge
reset  input  1  asynchronous, active-high; clears every register
rd_addr_1  input  3  register index for read port 1
rd_addr_2  input  3  register index for read port 2
wr_dst  input  3  register index written when wr_en=1
wr_data  input  256  write data
wr_en  input  1  write enable, sampled on rising clk
data_1  output  256  contents of register rd_addr_1 (with bypass)
data_2  output  256  contents of register rd_addr_2 (with bypass)

Behaviour:
- Storage: NUM_REGS registers of 256 bits each. Lane i occupies bits [16i+15:16i]; lane 0 is the LSBs. No register is hardwired; v0 is fully writable.
- Reset:
  - reset=1 asynchronously forces all registers to 0, independent of clk.
  - While reset is high, writes are ignored, so data_1 = data_2 = 0 unless bypass is active (see below).
  - Deasserting reset takes effect without waiting for a clock edge; the first write can occur on the first rising edge with reset low.
- Write:
  - On rising clk with reset=0 and wr_en=1: reg[wr_dst] <= wr_data, with all 256 bits written.
  - wr_en=0: no register changes.
  - Single write port, so no write conflicts.
- Read:
  - Combinational, zero latency. data_1 = reg[rd_addr_1] and data_2 = reg[rd_addr_2].
  - Both ports may address the same register; both then return the same value.
- Write-to-read bypass:
  - If wr_en=1 and wr_dst==rd_addr_N, data_N = wr_data in the same cycle, before the clock edge. This lets a result written in cycle t be consumed in cycle t.
  - Bypass is purely combinational and also applies while reset is high; the register itself is not written during reset.
- Reset mid-operation: a reset asserted in the same cycle as a write edge wins; the register stays 0.
- No X propagation: all outputs are defined from power-on reset onward.
- Addresses are 3 bits, so there is no out-of-range case at the default NUM_REGS. For non-power-of-two NUM_REGS:
  - Reads of an out-of-range index return 0.
  - Writes to an out-of-range index are dropped.

Test Plan:
- Reset clear: write distinct patterns to v0..v7, pulse reset mid-cycle (no clock edge) -> all reads 0 immediately; after release, reading any rd_addr -> 256'h0.
- Write/readback all regs: write reg k = {16{16'h1000+k}} for k=0..7 on successive edges, then read pairs (k, 7-k) -> data_1 = {16{16'h1000+k}}, data_2 = {16{16'h1007-k}}.
- Lane ordering: write v3 = lane i value i (lane 0 = 16'h0000 … lane 15 = 16'h000F) -> data_1[15:0]=16'h0000, data_1[255:240]=16'h000F.
- Bypass: v2 holds 256'hAAAA…; drive wr_en=1, wr_dst=2, wr_data=256'h5555…, rd_addr_1=2, rd_addr_2=3 before the edge -> data_1=256'h5555… immediately, data_2 unchanged; after the edge with wr_en=0 -> data_1 still 256'h5555….
- Write disable: wr_en=0, wr_dst=4, wr_data=all-ones across several edges -> v4 remains its prior value (0 after reset).
- Reset vs write collision: reset=1 and wr_en=1, wr_dst=5, wr_data=256'h1234… across an edge -> after reset low and wr_en low, v5 reads 0.

Source files
------------

// File: rtl/vector_reg_file.sv
// CVP14 vector register file: NUM_REGS x (ELEM_WIDTH*NUM_ELEMS) bits, two combinational
// read ports with same-cycle write bypass, one synchronous write port, async clear.
module vector_reg_file #(
    parameter int NUM_REGS   = 8,
    parameter int ELEM_WIDTH = 16,
    parameter int NUM_ELEMS  = 16,
    localparam int REG_W     = ELEM_WIDTH * NUM_ELEMS,
    localparam int ADDR_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    input  logic [ADDR_W-1:0] wr_dst,
    input  logic [REG_W-1:0]  wr_data,
    input  logic              wr_en,
    output logic [REG_W-1:0]  data_1,
    output logic [REG_W-1:0]  data_2
);

    logic [REG_W-1:0] regs_q [NUM_REGS];
    logic [REG_W-1:0] regs_d [NUM_REGS];
    logic             wr_hit_1;
    logic             wr_hit_2;

    // Decode the write by comparing against every valid index, so an
    // out-of-range wr_dst simply matches nothing and the write is dropped.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en && (wr_dst == ADDR_W'(i))) begin
                regs_d[i] = wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Bypass only for in-range destinations; it stays live during reset so a
    // result produced this cycle is visible even while storage is held clear.
    assign wr_hit_1 = wr_en && (wr_dst == rd_addr_1) && (32'(wr_dst) < NUM_REGS);
    assign wr_hit_2 = wr_en && (wr_dst == rd_addr_2) && (32'(wr_dst) < NUM_REGS);

    always_comb begin
        data_1 = '0;
        data_2 = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr_1 == ADDR_W'(i)) begin
                data_1 = regs_q[i];
            end
            if (rd_addr_2 == ADDR_W'(i)) begin
                data_2 = regs_q[i];
            end
        end
        if (wr_hit_1) begin
            data_1 = wr_data;
        end
        if (wr_hit_2) begin
            data_2 = wr_data;
        end
    end

endmodule

// File: tb/tb_vector_reg_file.sv
// Directed bench for vector_reg_file: reset clear, write/readback, lane order,
// bypass, write disable and reset/write collision.
module tb_vector_reg_file;

    localparam int W = 256;

    logic         clk;
    logic         reset;
    logic [2:0]   rd_addr_1;
    logic [2:0]   rd_addr_2;
    logic [2:0]   wr_dst;
    logic [W-1:0] wr_data;
    logic         wr_en;
    logic [W-1:0] data_1;
    logic [W-1:0] data_2;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] lane_pat;
    logic [W-1:0] pat_a;
    logic [W-1:0] pat_5;
    logic [W-1:0] pat_1234;
    logic [W-1:0] ones;
    logic [15:0]  lane_v;

    vector_reg_file dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr_1 (rd_addr_1),
        .rd_addr_2 (rd_addr_2),
        .wr_dst    (wr_dst),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .data_1    (data_1),
        .data_2    (data_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rep16(input logic [15:0] v);
        return {16{v}};
    endfunction

    task automatic write_reg(input logic [2:0] dst, input logic [W-1:0] val);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_dst  = dst;
        wr_data = val;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        rd_addr_1 = '0;
        rd_addr_2 = '0;
        wr_dst    = '0;
        wr_data   = '0;
        wr_en     = 1'b0;
        pat_a     = rep16(16'hAAAA);
        pat_5     = rep16(16'h5555);
        pat_1234  = rep16(16'h1234);
        ones      = '1;
        for (int i = 0; i < 16; i++) begin
            lane_v = 16'(i);
            lane_pat[16*i +: 16] = lane_v;
        end

        #1 reset = 1'b1;
        #2;
        check("reset_d1", data_1, '0);
        check("reset_d2", data_2, '0);
        @(negedge clk);
        reset = 1'b0;

        // Write/readback all registers, then read (k, 7-k) pairs.
        for (int k = 0; k < 8; k++) begin
            write_reg(3'(k), rep16(16'h1000 + 16'(k)));
        end
        for (int k = 0; k < 8; k++) begin
            rd_addr_1 = 3'(k);
            rd_addr_2 = 3'(7 - k);
            #1;
            check($sformatf("pair%0d_d1", k), data_1, rep16(16'h1000 + 16'(k)));
            check($sformatf("pair%0d_d2", k), data_2, rep16(16'h1007 - 16'(k)));
        end
        rd_addr_1 = 3'd6;
        rd_addr_2 = 3'd6;
        #1;
        check("same_addr_d1", data_1, rep16(16'h1006));
        check("same_addr_d2", data_2, rep16(16'h1006));

        // Reset pulse between edges clears everything immediately.
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("midreset_d1", data_1, '0);
        check("midreset_d2", data_2, '0);
        #1 reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rd_addr_1 = 3'(k);
            rd_addr_2 = 3'(7 - k);
            #0.1;
            check($sformatf("cleared%0d", k), data_1, '0);
        end

        // Lane ordering.
        write_reg(3'd3, lane_pat);
        rd_addr_1 = 3'd3;
        #1;
        check("lane0", W'(data_1[15:0]), W'(16'h0000));
        check("lane15", W'(data_1[255:240]), W'(16'h000F));
        check("lane_all", data_1, lane_pat);

        // Bypass: new value visible before the edge, other port untouched.
        write_reg(3'd2, pat_a);
        @(negedge clk);
        wr_en     = 1'b1;
        wr_dst    = 3'd2;
        wr_data   = pat_5;
        rd_addr_1 = 3'd2;
        rd_addr_2 = 3'd3;
        #1;
        check("bypass_d1", data_1, pat_5);
        check("bypass_d2", data_2, lane_pat);
        @(posedge clk);
        #1 wr_en = 1'b0;
        #1;
        check("bypass_commit", data_1, pat_5);

        // Write disabled across several edges.
        @(negedge clk);
        wr_en   = 1'b0;
        wr_dst  = 3'd4;
        wr_data = ones;
        rd_addr_1 = 3'd4;
        repeat (3) @(posedge clk);
        #1;
        check("wr_disable", data_1, '0);

        // Reset and write on the same edge: reset wins, bypass still live.
        @(negedge clk);
        reset     = 1'b1;
        wr_en     = 1'b1;
        wr_dst    = 3'd5;
        wr_data   = pat_1234;
        rd_addr_1 = 3'd5;
        rd_addr_2 = 3'd2;
        #1;
        check("rst_bypass_d1", data_1, pat_1234);
        check("rst_cleared_d2", data_2, '0);
        @(posedge clk);
        #1 wr_en = 1'b0;
        #1;
        check("collide_in_reset", data_1, '0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("collide_after", data_1, '0);

        // First write after release lands on the first edge.
        write_reg(3'd5, pat_a);
        rd_addr_2 = 3'd5;
        #1;
        check("post_reset_write", data_2, pat_a);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
